// File: rtl/wb_uart_tx_pkg.sv
// rtl/wb_uart_tx_pkg.sv - shared state encoding, line levels and counter sizing for wb_uart_tx
package wb_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_ACK = 3'd2,
    START    = 3'd3,
    DATA     = 3'd4,
    STOP     = 3'd5
  } state_t;

  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - CLKS_PER_BIT divider with synchronous clear and one-cycle tick
module uart_baud_tick
  import wb_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Tick marks the last cycle of the current bit period.
  assign o_tick = (count == LAST);

endmodule

// File: rtl/wb_uart_tx.sv
// rtl/wb_uart_tx.sv - Wishbone read master popping FIFO words onto an 8N1 UART TX line
module wb_uart_tx
  import wb_uart_tx_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_fifo_empty,
  output logic          o_tx,
  output logic          o_busy
);

  localparam int BW = $clog2(DW + 1);
  localparam int AW = cnt_width(ACK_TIMEOUT);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);
  // The strobe cycle counts toward the timeout, so WAIT_ACK lasts ACK_TIMEOUT-1 cycles.
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 2);

  state_t        state, state_next;
  logic [DW-1:0] shift, shift_next;
  logic [BW-1:0] bit_cnt, bit_cnt_next;
  logic [AW-1:0] ack_cnt, ack_cnt_next;
  logic          tx_next;
  logic          baud_clear;
  logic          baud_tick;
  logic          unused_stall;

  assign o_wb_we      = 1'b0;
  assign unused_stall = i_wb_stall;
  // Divider held at zero outside the line states, so START always begins a fresh bit period.
  assign baud_clear   = !(state inside {START, DATA, STOP});

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(baud_clear),
    .o_tick (baud_tick)
  );

  always_comb begin
    state_next   = state;
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    ack_cnt_next = ack_cnt;
    tx_next      = o_tx;
    case (state)
      IDLE: begin
        if (!i_fifo_empty) state_next = REQ;
      end
      REQ: begin
        ack_cnt_next = '0;
        state_next   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (i_wb_ack) begin
          shift_next = i_wb_data;
          tx_next    = UART_START_LEVEL;
          state_next = START;
        end else if (ack_cnt == ACK_LAST) begin
          state_next = IDLE;
        end else begin
          ack_cnt_next = ack_cnt + 1'b1;
        end
      end
      START: begin
        if (baud_tick) begin
          bit_cnt_next = '0;
          tx_next      = shift[0];
          state_next   = DATA;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == BIT_LAST) begin
            tx_next    = UART_IDLE_LEVEL;
            state_next = STOP;
          end else begin
            shift_next   = shift >> 1;
            bit_cnt_next = bit_cnt + 1'b1;
            tx_next      = shift_next[0];
          end
        end
      end
      STOP: begin
        if (baud_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      shift    <= '0;
      bit_cnt  <= '0;
      ack_cnt  <= '0;
      o_tx     <= UART_IDLE_LEVEL;
      o_wb_stb <= 1'b0;
      o_wb_cyc <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      bit_cnt  <= bit_cnt_next;
      ack_cnt  <= ack_cnt_next;
      o_tx     <= tx_next;
      o_wb_stb <= (state_next == REQ);
      o_wb_cyc <= (state_next inside {REQ, WAIT_ACK});
      o_busy   <= (state_next != IDLE);
    end
  end

endmodule
